uart_tx_apb_scheduler: RTL and testbench
========================================

Name: uart_tx_apb_scheduler

Overview:
APB master that configures the team's APB UART after reset, then shares its transmit path among NUM_REQ byte-stream requesters. Arbitration is round-robin. Before each data-register write the block polls the UART status register, so no byte is written while the TX FIFO is full (the UART silently drops such bytes). It sits between on-chip byte producers (debug, log, console) and the UART APB slave port.

Parameters:
NUM_REQ, 4, number of byte requesters (2..8)
APB_ADDR_WIDTH, 8, APB address width
APB_DATA_WIDTH, 32, APB data width
BAUD_DIV, 325, value written to BAUD (0x0C) at init
LCR_INIT, 3, value written to LCR (0x18) at init (8N1)
CR_INIT, 7, value written to CR (0x00) at init (EN|TXEN|RXEN)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid; held until matching req_ready
req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]; stable while valid
req_ready  out  NUM_REQ  one-cycle registered pulse: byte consumed
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
paddr  out  APB_ADDR_WIDTH  APB address
pwdata  out  APB_DATA_WIDTH  APB write data
prdata  in  APB_DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error
init_done  out  1  high once CR init write completes
apb_err  out  1  one-cycle pulse when a transfer completes with pslverr=1

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0, init_done=0, apb_err=0, rr pointer=0, state=INIT_BAUD.
- All outputs are registered.
- APB transfer:
  - SETUP cycle: psel=1, penable=0, address/data/pwrite valid.
  - ACCESS cycle(s): psel=1, penable=1, all signals held until pready=1.
  - Completion is the clock edge where penable&&pready; psel/penable drop next cycle unless a back-to-back SETUP follows.
  - pwdata=0 on reads.
- States: INIT_BAUD -> INIT_LCR -> INIT_CR -> IDLE -> POLL -> WRITE -> IDLE. Each APB state contains its own SETUP/ACCESS phase.
- INIT_BAUD writes 0x0C=BAUD_DIV. INIT_LCR writes 0x18=LCR_INIT. INIT_CR writes 0x00=CR_INIT; init_done goes to 1 at its completion and stays 1 until reset.
- Init writes run back-to-back: the SETUP of the next write is the cycle after the previous completion.
- IDLE (one cycle minimum): if any req_valid -> POLL, else stay.
- POLL reads SR (0x04). At completion:
  - If prdata[1] (TXFULL)=1 -> IDLE, retry later.
  - Else pick winner g = first i with req_valid[i]=1, scanning from rr pointer upward mod NUM_REQ.
  - Latch req_data[g] and g; set rr pointer=(g+1) mod NUM_REQ; -> WRITE.
  - If no req_valid -> IDLE.
- WRITE writes DR (0x08), pwdata={24'h0, latched byte}. At completion req_ready[g]=1 for exactly the next cycle; -> IDLE.
- The mandatory IDLE cycle after every DR write guarantees the next SR read sees the UART's registered (one-cycle-late) status.
- Latency, zero-wait slave, requester valid in IDLE at cycle 0:
  - SR SETUP c1, SR ACCESS c2.
  - DR SETUP c3, DR ACCESS c4.
  - req_ready c5.
  - Next SR SETUP no earlier than c6.
- Wait states: any number of pready=0 cycles only stretches ACCESS; no timeout.
- pslverr:
  - apb_err pulses at completion.
  - Init errors do not retry; the sequence proceeds.
  - A POLL error is treated as full -> IDLE.
  - A WRITE error still acks the requester (byte lost, reported via apb_err).
- Fairness: a requester that holds valid is served within NUM_REQ grants.
- Simultaneous: requests arriving during POLL ACCESS count at POLL completion. A valid dropped before POLL completion is not granted.
- No requests are acked before init_done=1.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). The latched byte is discarded without req_ready. Init restarts from INIT_BAUD.

Test Plan:
1. Reset release, zero-wait slave -> writes 0x0C=325, 0x18=3, 0x00=7 on consecutive transfers (SETUP c1, c3, c5); init_done=1 after the c6 completion edge; no reads before.
2. After init, req_valid=4'b0001, data=0x41 -> SR read, DR write pwdata=0x41, req_ready[0] pulses one cycle 5 cycles after request seen in IDLE.
3. All four valid continuously, rr=0 -> grants 0,1,2,3,0 in order; each req_ready single-cycle; each DR write preceded by an SR read.
4. SR returns TXFULL=1 three times, then 0 -> three POLL->IDLE loops with no DR write, then one DR write and one ack.
5. pready held low 5 cycles on DR write -> signals stable throughout; ack 1 cycle after completion; pslverr=1 on that completion -> apb_err pulse, ack still issued.
6. resetn asserted during DR ACCESS -> psel/penable/req_ready drop immediately; after release, init sequence reruns from BAUD; pending requester is served after init.

Source files
------------

// File: rtl/uart_tx_apb_scheduler.sv
// APB master that configures the UART after reset, then round-robins NUM_REQ
// byte streams onto its data register, polling TX-FIFO status before each byte.
module uart_tx_apb_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int BAUD_DIV       = 325,
    parameter int LCR_INIT       = 3,
    parameter int CR_INIT        = 7
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [8*NUM_REQ-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic                      init_done_o,
    output logic                      apb_err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CR   = APB_ADDR_WIDTH'(8'h00);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_SR   = APB_ADDR_WIDTH'(8'h04);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_DR   = APB_ADDR_WIDTH'(8'h08);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_BAUD = APB_ADDR_WIDTH'(8'h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_LCR  = APB_ADDR_WIDTH'(8'h18);

    localparam logic [APB_DATA_WIDTH-1:0] BAUD_WD = APB_DATA_WIDTH'(BAUD_DIV);
    localparam logic [APB_DATA_WIDTH-1:0] LCR_WD  = APB_DATA_WIDTH'(LCR_INIT);
    localparam logic [APB_DATA_WIDTH-1:0] CR_WD   = APB_DATA_WIDTH'(CR_INIT);

    typedef enum logic [2:0] {
        ST_INIT_BAUD = 3'd0,
        ST_INIT_LCR  = 3'd1,
        ST_INIT_CR   = 3'd2,
        ST_IDLE      = 3'd3,
        ST_POLL      = 3'd4,
        ST_WRITE     = 3'd5
    } state_e;

    state_e                      state_q;
    logic                        psel_q;
    logic                        penable_q;
    logic                        pwrite_q;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q;
    logic [NUM_REQ-1:0]          req_ready_q;
    logic                        init_done_q;
    logic                        apb_err_q;
    logic [IDX_W-1:0]            rr_q;
    logic [IDX_W-1:0]            gnt_q;

    logic                        win_found_s;
    logic [IDX_W-1:0]            win_idx_s;
    logic [IDX_W-1:0]            rr_d;
    logic [APB_DATA_WIDTH-1:0]   win_wdata_s;
    logic                        txfull_s;
    logic                        prdata_unused_s;

    assign txfull_s        = prdata_i[1];
    assign prdata_unused_s = ^{prdata_i[APB_DATA_WIDTH-1:2], prdata_i[0]};

    // Round-robin winner: scan downward so the lowest offset from rr_q wins last.
    always_comb begin
        int pos;
        pos         = 0;
        win_found_s = 1'b0;
        win_idx_s   = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos         = (int'(rr_q) + k) % NUM_REQ;
            win_idx_s   = req_valid_i[pos] ? IDX_W'(pos) : win_idx_s;
            win_found_s = win_found_s | req_valid_i[pos];
        end
        rr_d        = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
        win_wdata_s = APB_DATA_WIDTH'(req_data_i[{win_idx_s, 3'b000} +: 8]);
    end

    // Control FSM; every APB state carries its own SETUP/ACCESS phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT_BAUD;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            init_done_q <= 1'b0;
            apb_err_q   <= 1'b0;
            rr_q        <= '0;
            gnt_q       <= '0;
        end else begin
            req_ready_q <= '0;
            apb_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        state_q   <= ST_POLL;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= ADDR_SR;
                        pwdata_q  <= '0;
                    end
                end
                ST_INIT_BAUD, ST_INIT_LCR, ST_INIT_CR, ST_POLL, ST_WRITE: begin
                    if (!psel_q) begin
                        // Only reachable straight out of reset: launch the BAUD write.
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= ADDR_BAUD;
                        pwdata_q <= BAUD_WD;
                    end else if (!penable_q) begin
                        penable_q <= 1'b1;
                    end else if (pready_i) begin
                        apb_err_q <= pslverr_i;
                        penable_q <= 1'b0;
                        psel_q    <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        state_q   <= ST_IDLE;
                        case (state_q)
                            ST_INIT_BAUD: begin
                                state_q  <= ST_INIT_LCR;
                                psel_q   <= 1'b1;
                                pwrite_q <= 1'b1;
                                paddr_q  <= ADDR_LCR;
                                pwdata_q <= LCR_WD;
                            end
                            ST_INIT_LCR: begin
                                state_q  <= ST_INIT_CR;
                                psel_q   <= 1'b1;
                                pwrite_q <= 1'b1;
                                paddr_q  <= ADDR_CR;
                                pwdata_q <= CR_WD;
                            end
                            ST_INIT_CR: begin
                                init_done_q <= 1'b1;
                            end
                            ST_POLL: begin
                                // A slave error on the status read is treated like TXFULL.
                                if (!pslverr_i && !txfull_s && win_found_s) begin
                                    state_q  <= ST_WRITE;
                                    psel_q   <= 1'b1;
                                    pwrite_q <= 1'b1;
                                    paddr_q  <= ADDR_DR;
                                    pwdata_q <= win_wdata_s;
                                    gnt_q    <= win_idx_s;
                                    rr_q     <= rr_d;
                                end
                            end
                            ST_WRITE: begin
                                req_ready_q[gnt_q] <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_INIT_BAUD;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q   <= ST_INIT_BAUD;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    pwrite_q  <= 1'b0;
                    paddr_q   <= '0;
                    pwdata_q  <= '0;
                end
            endcase
        end
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign req_ready_o = req_ready_q;
    assign init_done_o = init_done_q;
    assign apb_err_o   = apb_err_q;

endmodule

// File: tb/tb_uart_tx_apb_scheduler.sv
// Directed bench: a behavioural APB UART slave plus requester model, a table of
// per-grant vectors, and hand-written reset/init sequences.
module tb_uart_tx_apb_scheduler;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, init_done, apb_err;

    always #5 clk = ~clk;

    uart_tx_apb_scheduler #(
        .NUM_REQ(4), .APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(32),
        .BAUD_DIV(325), .LCR_INIT(3), .CR_INIT(7)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
        .pready_i(pready), .pslverr_i(pslverr),
        .init_done_o(init_done), .apb_err_o(apb_err)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / slave state
    int ack_cnt = 0, ack_idx = -1, ack_cyc = 0, ack_pop = 0, last_ack_cyc = -100;
    int err_cnt = 0, sr_reads = 0, dr_writes = 0, sr_setup_cyc = 0;
    int gap_viol = 0, early_ack = 0, early_read = 0, unstable = 0, stretched = 0, rd_wdata_viol = 0;
    int wait_cnt = 0, init_n = 0;
    bit in_dr_wait = 1'b0;
    logic [31:0] dr_data = 32'h0;
    logic [7:0]  init_addr [3];
    logic [31:0] init_data [3];
    int          init_cyc  [3];
    logic [7:0]  cap_addr;
    logic [31:0] cap_data;
    logic        cap_write;
    int          cap_cyc;
    int cfg_waits = 0, cfg_full_left = 0, cfg_srerr_left = 0;
    bit cfg_dr_err = 1'b0;

    typedef struct {
        logic [3:0] mask;
        int         full_n;
        int         srerr_n;
        int         waits;
        bit         dr_err;
        int         exp_g;
        logic [7:0] exp_byte;
        int         exp_polls;
        int         exp_errs;
        int         exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ack(input int start, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk); #2;
            if (ack_cnt != start) ok = 1'b1;
        end
    endtask

    task automatic check_init(input string tag, input int base);
        chk({tag, "_baud_addr"}, 32'(init_addr[0]), 32'h0C);
        chk({tag, "_baud_data"}, init_data[0], 32'd325);
        chk({tag, "_lcr_addr"},  32'(init_addr[1]), 32'h18);
        chk({tag, "_lcr_data"},  init_data[1], 32'd3);
        chk({tag, "_cr_addr"},   32'(init_addr[2]), 32'h00);
        chk({tag, "_cr_data"},   init_data[2], 32'd7);
        chk({tag, "_baud_setup_cyc"}, 32'(init_cyc[0] - base), 32'd1);
        chk({tag, "_lcr_setup_cyc"},  32'(init_cyc[1] - base), 32'd3);
        chk({tag, "_cr_setup_cyc"},   32'(init_cyc[2] - base), 32'd5);
    endtask

    // APB slave, requester handshake and protocol monitor, all on the falling edge.
    always @(negedge clk) begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        if (!resetn) begin
            wait_cnt = 0;
        end else begin
            if (req_ready != 4'b0) begin
                ack_cnt++;
                ack_cyc      = cyc;
                last_ack_cyc = cyc;
                ack_pop      = $countones(req_ready);
                for (int i = 0; i < NR; i++) if (req_ready[i]) ack_idx = i;
                if (!init_done) early_ack++;
                req_valid = req_valid & ~req_ready;
            end
            if (apb_err) err_cnt++;
            if (psel && !penable) begin
                cap_addr = paddr; cap_data = pwdata; cap_write = pwrite; cap_cyc = cyc;
                if (!pwrite && paddr == 8'h04) begin
                    sr_setup_cyc = cyc;
                    if (cyc <= last_ack_cyc) gap_viol++;
                end
            end
            if (psel && penable) begin
                if ({paddr, pwdata, pwrite} !== {cap_addr, cap_data, cap_write}) unstable++;
                if (pwrite && paddr == 8'h08 && wait_cnt < cfg_waits) begin
                    wait_cnt++;
                    in_dr_wait = 1'b1;
                end else begin
                    pready = 1'b1;
                    if (wait_cnt > 0) stretched++;
                    wait_cnt = 0;
                    if (!pwrite) begin
                        sr_reads++;
                        if (!init_done) early_read++;
                        if (pwdata != 32'h0) rd_wdata_viol++;
                        if (cfg_srerr_left > 0) begin
                            pslverr = 1'b1; cfg_srerr_left--; prdata = 32'hFFFF_FFFD;
                        end else if (cfg_full_left > 0) begin
                            prdata = 32'hFFFF_FFFF; cfg_full_left--;
                        end else begin
                            prdata = 32'hFFFF_FFFD;
                        end
                    end else if (paddr == 8'h08) begin
                        dr_writes++;
                        dr_data = pwdata;
                        pslverr = cfg_dr_err;
                    end else if (init_n < 3) begin
                        init_addr[init_n] = paddr;
                        init_data[init_n] = pwdata;
                        init_cyc[init_n]  = cap_cyc;
                        init_n++;
                    end
                end
            end
        end
    end

    initial begin
        bit ok;
        int base;
        // mask, full, srerr, waits, dr_err, grant, byte, polls, errs, latency
        vecs[0]  = '{4'b0001, 0, 0, 0, 1'b0, 0, 8'h41, 1, 0, 4};
        vecs[1]  = '{4'b1000, 0, 0, 0, 1'b0, 3, 8'h7E, 1, 0, 4};
        vecs[2]  = '{4'b1111, 0, 0, 0, 1'b0, 0, 8'h41, 1, 0, 4};
        vecs[3]  = '{4'b0001, 0, 0, 0, 1'b0, 1, 8'hFF, 1, 0, 4};
        vecs[4]  = '{4'b0000, 0, 0, 0, 1'b0, 2, 8'h00, 1, 0, 4};
        vecs[5]  = '{4'b0000, 0, 0, 0, 1'b0, 3, 8'h7E, 1, 0, 4};
        vecs[6]  = '{4'b0000, 0, 0, 0, 1'b0, 0, 8'h41, 1, 0, 4};
        vecs[7]  = '{4'b0100, 3, 0, 0, 1'b0, 2, 8'h00, 4, 0, 4};
        vecs[8]  = '{4'b0010, 0, 0, 5, 1'b1, 1, 8'hFF, 1, 1, 9};
        vecs[9]  = '{4'b0001, 0, 2, 0, 1'b0, 0, 8'h41, 3, 2, 4};
        vecs[10] = '{4'b1010, 0, 0, 0, 1'b0, 1, 8'hFF, 1, 0, 4};
        vecs[11] = '{4'b0000, 0, 0, 0, 1'b0, 3, 8'h7E, 1, 0, 4};

        req_valid = 4'b0;
        req_data  = 32'h7E00_FF41;
        resetn    = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_apb_err", 32'(apb_err), 32'd0);

        // Init sequence with a zero-wait slave
        base   = cyc;
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        chk("init_cr_access_penable", 32'(penable), 32'd1);
        chk("init_done_before_cr_done", 32'(init_done), 32'd0);
        @(negedge clk); #2;
        chk("init_done_after_cr_done", 32'(init_done), 32'd1);
        chk("idle_psel_after_init", 32'(psel), 32'd0);
        check_init("init", base);
        chk("reads_before_init", 32'(early_read), 32'd0);

        // Table-driven grants
        for (int k = 0; k < 12; k++) begin
            sr_reads = 0; dr_writes = 0; err_cnt = 0;
            cfg_full_left  = vecs[k].full_n;
            cfg_srerr_left = vecs[k].srerr_n;
            cfg_waits      = vecs[k].waits;
            cfg_dr_err     = vecs[k].dr_err;
            req_valid      = req_valid | vecs[k].mask;
            wait_ack(ack_cnt, 400, ok);
            chk($sformatf("v%0d_ack_seen", k), 32'(ok), 32'd1);
            chk($sformatf("v%0d_grant", k), 32'(ack_idx), 32'(vecs[k].exp_g));
            chk($sformatf("v%0d_dr_data", k), dr_data, {24'h0, vecs[k].exp_byte});
            chk($sformatf("v%0d_sr_reads", k), 32'(sr_reads), 32'(vecs[k].exp_polls));
            chk($sformatf("v%0d_dr_writes", k), 32'(dr_writes), 32'd1);
            chk($sformatf("v%0d_apb_err", k), 32'(err_cnt), 32'(vecs[k].exp_errs));
            chk($sformatf("v%0d_latency", k), 32'(ack_cyc - sr_setup_cyc), 32'(vecs[k].exp_lat));
            chk($sformatf("v%0d_ack_onehot", k), 32'(ack_pop), 32'd1);
            @(negedge clk); #2;
            chk($sformatf("v%0d_ack_width", k), 32'(req_ready), 32'd0);
        end
        cfg_waits = 0; cfg_dr_err = 1'b0;

        // Reset in the middle of a stretched DR write
        cfg_waits  = 20;
        in_dr_wait = 1'b0;
        req_valid  = req_valid | 4'b0100;
        for (int n = 0; n < 100 && !in_dr_wait; n++) begin
            @(negedge clk); #2;
        end
        chk("mid_reset_reached_dr_access", 32'(in_dr_wait), 32'd1);
        base   = ack_cnt;
        resetn = 1'b0;
        #1;
        chk("mid_reset_psel", 32'(psel), 32'd0);
        chk("mid_reset_penable", 32'(penable), 32'd0);
        chk("mid_reset_req_ready", 32'(req_ready), 32'd0);
        chk("mid_reset_init_done", 32'(init_done), 32'd0);
        cfg_waits = 0;
        init_n    = 0;
        repeat (2) @(negedge clk);
        #2;
        chk("mid_reset_no_ack", 32'(ack_cnt - base), 32'd0);
        sr_reads = 0; dr_writes = 0;
        base   = cyc;
        resetn = 1'b1;
        wait_ack(ack_cnt, 400, ok);
        chk("post_reset_ack_seen", 32'(ok), 32'd1);
        chk("post_reset_grant", 32'(ack_idx), 32'd2);
        chk("post_reset_dr_data", dr_data, 32'h0);
        chk("post_reset_dr_writes", 32'(dr_writes), 32'd1);
        check_init("reinit", base);

        chk("ack_before_init_done", 32'(early_ack), 32'd0);
        chk("read_before_init_done", 32'(early_read), 32'd0);
        chk("sr_read_without_idle_gap", 32'(gap_viol), 32'd0);
        chk("access_signal_changes", 32'(unstable), 32'd0);
        chk("stretched_transfer_seen", 32'(stretched > 0), 32'd1);
        chk("nonzero_pwdata_on_read", 32'(rd_wdata_viol), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
